// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage constants and types: reset/handler vectors, legal fetch window and
// fetch-side exception codes. CP0 and the pipeline registers use the same values.
package if_fetch_unit_pkg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LAST    = 32'h0000_6ffc;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Source of the next PC, in decreasing priority below reset.
    typedef enum logic [2:0] {
        PcHandler,
        PcHold,
        PcEret,
        PcJump,
        PcSeq
    } pc_sel_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
    } instr_fields_t;

    function automatic logic fetch_addr_fault(logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    endfunction

endpackage

// File: rtl/fetch_exc_check.sv
// Combinational fetch-address check: flags AdEL for misaligned or out-of-window PCs.
module fetch_exc_check
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    output logic        adel_o,
    output logic [4:0]  exc_code_o
);

    always_comb begin
        adel_o     = fetch_addr_fault(pc_i);
        exc_code_o = adel_o ? EXC_ADEL : EXC_NONE;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch unit: PC register, next-PC selection, instruction-memory address and
// decode of the fetched word into the IF_* bundle for the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic        ID_jump_en,
    input  logic [31:0] ID_jump_target,
    input  logic        ID_is_cti,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] IF_pc,
    output logic [5:0]  IF_op,
    output logic [5:0]  IF_func,
    output logic [4:0]  IF_rs,
    output logic [4:0]  IF_rt,
    output logic [4:0]  IF_rd,
    output logic [15:0] IF_immediate,
    output logic [25:0] IF_instrIndex,
    output logic        IF_BD,
    output logic [4:0]  IF_ExcCode
);

    logic [31:0]   pc_q, pc_d;
    pc_sel_e       pc_sel;
    logic          adel;
    logic [4:0]    exc_code;
    logic [31:0]   instr;
    instr_fields_t fields;

    // Req beats stall so the handler fetch is never blocked; stall beats redirects
    // because ID holds and re-presents them.
    always_comb begin
        pc_sel = PcSeq;
        if (Req) begin
            pc_sel = PcHandler;
        end else if (stall) begin
            pc_sel = PcHold;
        end else if (eret) begin
            pc_sel = PcEret;
        end else if (ID_jump_en) begin
            pc_sel = PcJump;
        end
    end

    always_comb begin
        pc_d = pc_q + 32'd4;
        unique case (pc_sel)
            PcHandler: pc_d = PC_HANDLER;
            PcHold:    pc_d = pc_q;
            PcEret:    pc_d = EPC;
            PcJump:    pc_d = ID_jump_target;
            PcSeq:     pc_d = pc_q + 32'd4;
            default:   pc_d = pc_q + 32'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_exc_check u_fetch_exc_check (
        .pc_i       (pc_q),
        .adel_o     (adel),
        .exc_code_o (exc_code)
    );

    // A faulting fetch is presented as a nop; the PC itself is kept for EPC/BadVAddr.
    always_comb begin
        instr  = adel ? 32'd0 : i_inst_rdata;
        fields = instr_fields_t'(instr);

        i_inst_addr   = pc_q;
        IF_pc         = pc_q;
        IF_op         = fields.op;
        IF_rs         = fields.rs;
        IF_rt         = fields.rt;
        IF_rd         = fields.rd;
        IF_func       = fields.func;
        IF_immediate  = instr[15:0];
        IF_instrIndex = instr[25:0];
        IF_BD         = ID_is_cti & ~Req;
        IF_ExcCode    = exc_code;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by randomized
// control traffic, all compared against a behavioural PC/fetch model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, Req, eret, ID_jump_en, ID_is_cti;
    logic [31:0] EPC, ID_jump_target, i_inst_rdata;
    logic [31:0] i_inst_addr, IF_pc;
    logic [5:0]  IF_op, IF_func;
    logic [4:0]  IF_rs, IF_rt, IF_rd, IF_ExcCode;
    logic [15:0] IF_immediate;
    logic [25:0] IF_instrIndex;
    logic        IF_BD;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .Req            (Req),
        .eret           (eret),
        .EPC            (EPC),
        .ID_jump_en     (ID_jump_en),
        .ID_jump_target (ID_jump_target),
        .ID_is_cti      (ID_is_cti),
        .i_inst_addr    (i_inst_addr),
        .i_inst_rdata   (i_inst_rdata),
        .IF_pc          (IF_pc),
        .IF_op          (IF_op),
        .IF_func        (IF_func),
        .IF_rs          (IF_rs),
        .IF_rt          (IF_rt),
        .IF_rd          (IF_rd),
        .IF_immediate   (IF_immediate),
        .IF_instrIndex  (IF_instrIndex),
        .IF_BD          (IF_BD),
        .IF_ExcCode     (IF_ExcCode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s pc=%h observed=%h expected=%h", tag, model_pc, obs, exp);
        end
    endtask

    // Check the current outputs, then clock once and advance the model.
    task automatic cycle();
        logic        fault;
        logic [31:0] word;
        logic [31:0] nxt;
        i_inst_rdata = $urandom;
        #1;
        fault = (model_pc % 4 != 0) || (model_pc < 32'h3000) || (model_pc > 32'h6ffc);
        word  = fault ? 32'd0 : i_inst_rdata;
        chk("pc",    IF_pc,                 model_pc);
        chk("iaddr", i_inst_addr,           model_pc);
        chk("op",    {26'd0, IF_op},        word / (1 << 26));
        chk("rs",    {27'd0, IF_rs},        (word / (1 << 21)) % 32);
        chk("rt",    {27'd0, IF_rt},        (word / (1 << 16)) % 32);
        chk("rd",    {27'd0, IF_rd},        (word / (1 << 11)) % 32);
        chk("func",  {26'd0, IF_func},      word % 64);
        chk("imm",   {16'd0, IF_immediate}, word % 65536);
        chk("index", {6'd0, IF_instrIndex}, word % (1 << 26));
        chk("bd",    {31'd0, IF_BD},        (ID_is_cti && !Req) ? 32'd1 : 32'd0);
        chk("exc",   {27'd0, IF_ExcCode},   fault ? 32'd4 : 32'd0);

        if (reset)           nxt = 32'h3000;
        else if (Req)        nxt = 32'h4180;
        else if (stall)      nxt = model_pc;
        else if (eret)       nxt = EPC;
        else if (ID_jump_en) nxt = ID_jump_target;
        else                 nxt = model_pc + 32'd4;
        @(posedge clk);
        #1;
        model_pc = nxt;
    endtask

    task automatic idle();
        reset = 0; stall = 0; Req = 0; eret = 0; ID_jump_en = 0; ID_is_cti = 0;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        idle();
        ID_jump_en = 1; ID_jump_target = tgt; ID_is_cti = 1;
        cycle();
        idle();
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'h3000 + ($urandom_range(0, 32'h3fff) & ~32'd3);
    endfunction

    initial begin
        idle();
        EPC = 0; ID_jump_target = 0; i_inst_rdata = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        model_pc = 32'h3000;
        reset = 0;

        // Sequential advance from reset: 3000, 3004, 3008.
        repeat (3) cycle();

        // Stall three cycles at 300c, then release to 3010.
        stall = 1;
        repeat (3) cycle();
        stall = 0;
        repeat (5) cycle();

        // Taken jump at 3020 with the delay-slot flag.
        jump_to(32'h3100);

        // eret to 3040, then Req together with stall and a CTI in ID.
        eret = 1; EPC = 32'h3040;
        cycle();
        idle();
        Req = 1; stall = 1; ID_is_cti = 1;
        cycle();
        idle();
        cycle();

        // Misaligned jump target faults in IF on the next cycle.
        jump_to(32'h3102);
        cycle();

        // eret to 3204 with a jump also asserted: eret wins.
        eret = 1; EPC = 32'h3204; ID_jump_en = 1; ID_jump_target = 32'h3300;
        cycle();
        idle();
        cycle();

        // stall holding a pending jump, then the jump lands.
        stall = 1; ID_jump_en = 1; ID_jump_target = 32'h3500;
        repeat (2) cycle();
        stall = 0;
        cycle();
        idle();

        // Top of the window: 6ffc is legal, 7000 raises AdEL.
        jump_to(32'h6ffc);
        repeat (2) cycle();

        // Wrap from ffff_fffc to 0.
        jump_to(32'hffff_fffc);
        repeat (2) cycle();

        // Mid-stream reset overrides Req and a jump in the same edge.
        reset = 1; Req = 1; ID_jump_en = 1; ID_jump_target = 32'h3800;
        cycle();
        idle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 63) == 0);
            Req            = ($urandom_range(0, 15) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            eret           = ($urandom_range(0, 7) == 0);
            ID_jump_en     = ($urandom_range(0, 3) == 0);
            ID_is_cti      = $urandom_range(0, 1) == 1;
            ID_jump_target = rand_target();
            EPC            = rand_target();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
